// File: rtl/fc_argmax_decider_if.sv
// Score-stream interface for the argmax decider.
// slave  : decider side (consumes scores, produces decision/readback).
// master : producer/observer side.
// Signals:
//   valid_in, data_in, clear : score stream and partial-frame abort
//   rd_addr / rd_data        : score buffer readback
//   decision, max_score      : winner of the last completed frame
//   valid_out                : one-cycle pulse on decision update
//   frame_cnt, busy          : completed-frame count, partial-frame flag
interface fc_argmax_decider_if #(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned IDX_BITS  = 4,
  parameter int unsigned CNT_BITS  = 8
);
  logic                 valid_in;
  logic [DATA_BITS-1:0] data_in;
  logic                 clear;
  logic [IDX_BITS-1:0]  rd_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic [IDX_BITS-1:0]  decision;
  logic [DATA_BITS-1:0] max_score;
  logic                 valid_out;
  logic [CNT_BITS-1:0]  frame_cnt;
  logic                 busy;

  modport slave (
    input  valid_in, data_in, clear, rd_addr,
    output rd_data, decision, max_score, valid_out, frame_cnt, busy
  );

  modport master (
    output valid_in, data_in, clear, rd_addr,
    input  rd_data, decision, max_score, valid_out, frame_cnt, busy
  );
endinterface

// File: rtl/fc_argmax_decider.sv
// Terminal classification stage: tracks the running signed maximum over a
// serial frame of NUM_CLASSES scores and emits the winning index/score with
// a one-cycle valid pulse. Keeps the last scores for readback and counts
// completed frames.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fc_argmax_decider_if.slave (stream in, decision/readback out)
module fc_argmax_decider #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned IDX_BITS    = 4,
  parameter int unsigned CNT_BITS    = 8
) (
  input logic                clk,
  input logic                rst_n,
  fc_argmax_decider_if.slave bus
);

  localparam logic [IDX_BITS-1:0] LastIdx = IDX_BITS'(NUM_CLASSES - 1);

  logic [IDX_BITS-1:0]         cls_idx_q, cls_idx_d;
  logic signed [DATA_BITS-1:0] run_max_q, run_max_d;
  logic [IDX_BITS-1:0]         run_idx_q, run_idx_d;
  logic [IDX_BITS-1:0]         decision_q, decision_d;
  logic [DATA_BITS-1:0]        max_score_q, max_score_d;
  logic                        valid_q, valid_d;
  logic [CNT_BITS-1:0]         frame_cnt_q, frame_cnt_d;
  logic [DATA_BITS-1:0]        buf_q [NUM_CLASSES];

  logic                        accept;
  logic                        take_new;
  logic signed [DATA_BITS-1:0] din_s;
  logic signed [DATA_BITS-1:0] win_max;
  logic [IDX_BITS-1:0]         win_idx;

  assign din_s  = $signed(bus.data_in);
  // clear has priority over a coincident sample
  assign accept = bus.valid_in && !bus.clear;

  always_comb begin
    // First sample of a frame always seeds the running max; afterwards only a
    // strictly greater score wins, so ties keep the lower index.
    take_new = (cls_idx_q == '0) || (din_s > run_max_q);
    win_max  = take_new ? din_s : run_max_q;
    win_idx  = take_new ? cls_idx_q : run_idx_q;

    cls_idx_d   = cls_idx_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    decision_d  = decision_q;
    max_score_d = max_score_q;
    valid_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (bus.clear) begin
      cls_idx_d = '0;
      run_max_d = '0;
      run_idx_d = '0;
    end else if (accept) begin
      run_max_d = win_max;
      run_idx_d = win_idx;
      if (cls_idx_q == LastIdx) begin
        // Final compare folded into the completion edge
        cls_idx_d   = '0;
        decision_d  = win_idx;
        max_score_d = win_max;
        valid_d     = 1'b1;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        cls_idx_d = cls_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_idx_q   <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      decision_q  <= '0;
      max_score_q <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      cls_idx_q   <= cls_idx_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      decision_q  <= decision_d;
      max_score_q <= max_score_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      if (accept) begin
        buf_q[cls_idx_q] <= bus.data_in;
      end
    end
  end

  assign bus.decision  = decision_q;
  assign bus.max_score = max_score_q;
  assign bus.valid_out = valid_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.busy      = (cls_idx_q != '0);
  assign bus.rd_data   = (bus.rd_addr <= LastIdx) ? buf_q[bus.rd_addr] : '0;

endmodule

// File: tb/tb_fc_argmax_decider.sv
// Self-checking bench for fc_argmax_decider: directed frames from the test
// plan followed by randomized frames with gaps and clears, all checked every
// cycle against a frame-level argmax reference model.
module tb_fc_argmax_decider;

  localparam int NC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_argmax_decider_if bus ();

  fc_argmax_decider dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int n_m;
  int sc_m [NC];
  int buf_m [NC];
  int dec_m, max_m, cnt_m;
  bit vld_m;

  task automatic model_reset();
    n_m = 0; dec_m = 0; max_m = 0; cnt_m = 0; vld_m = 0;
    for (int i = 0; i < NC; i++) begin
      sc_m[i] = 0;
      buf_m[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int a;
    logic [31:0] exp_rd;
    a = int'(bus.rd_addr);
    exp_rd = (a < NC) ? 32'(buf_m[a] & 32'hFFF) : 32'h0;
    chk("valid_out", 32'(bus.valid_out), 32'(vld_m));
    chk("decision",  32'(bus.decision),  32'(dec_m));
    chk("max_score", 32'(bus.max_score), 32'(max_m & 32'hFFF));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(cnt_m));
    chk("busy",      32'(bus.busy),      32'(n_m != 0));
    chk("rd_data",   32'(bus.rd_data),   exp_rd);
  endtask

  // One clock: drive inputs, advance model, check outputs 1ns after the edge
  task automatic step(input bit v, input int d, input bit c);
    int best;
    bus.valid_in = v;
    bus.data_in  = d[11:0];
    bus.clear    = c;
    bus.rd_addr  = 4'($urandom_range(0, 15));
    @(posedge clk);
    vld_m = 0;
    if (c) begin
      n_m = 0;
    end else if (v) begin
      sc_m[n_m]  = d;
      buf_m[n_m] = d;
      n_m++;
      if (n_m == NC) begin
        best = 0;
        for (int i = 1; i < NC; i++) if (sc_m[i] > sc_m[best]) best = i;
        dec_m = best;
        max_m = sc_m[best];
        vld_m = 1;
        cnt_m = (cnt_m + 1) % 256;
        n_m   = 0;
      end
    end
    #1;
    check_all();
    bus.valid_in = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic send_frame(input int s[NC], input int gap);
    for (int i = 0; i < NC; i++) begin
      step(1'b1, s[i], 1'b0);
      repeat (gap) step(1'b0, 0, 1'b0);
    end
  endtask

  int f [NC];

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.clear    = 1'b0;
    bus.rd_addr  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Ascending scores
    for (int i = 0; i < NC; i++) f[i] = 10 * i;
    send_frame(f, 0);
    step(1'b0, 0, 1'b0);
    bus.rd_addr = 4'd4;
    #1;
    chk("rd_data_addr4", 32'(bus.rd_data), 32'd40);
    chk("decision_t1", 32'(bus.decision), 32'd9);

    // Tie between classes 3 and 7
    for (int i = 0; i < NC; i++) f[i] = -5;
    f[3] = -2; f[7] = -2;
    send_frame(f, 0);
    chk("tie_max", 32'(bus.max_score), 32'hFFE);

    // All negative, descending
    for (int i = 0; i < NC; i++) f[i] = -100 * (i + 1);
    send_frame(f, 1);

    // Ascending with 3 idle cycles between scores
    for (int i = 0; i < NC; i++) f[i] = 10 * i;
    send_frame(f, 3);

    // Partial frame, clear, then full frame
    for (int i = 0; i < 5; i++) step(1'b1, 7 * i, 1'b0);
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < NC; i++) f[i] = i;
    f[6] = 500;
    send_frame(f, 0);

    // Clear coinciding with the 10th sample
    for (int i = 0; i < NC - 1; i++) step(1'b1, 3 * i, 1'b0);
    step(1'b1, 2000, 1'b1);
    step(1'b0, 0, 1'b0);

    // Back-to-back frames, maxima at 2 and 8
    for (int i = 0; i < NC; i++) f[i] = i;
    f[2] = 300;
    send_frame(f, 0);
    for (int i = 0; i < NC; i++) f[i] = -i;
    f[8] = 1200;
    send_frame(f, 0);
    step(1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 4; i++) step(1'b1, 50 + i, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NC; i++) f[i] = 100 - 20 * i;
    f[5] = 900;
    send_frame(f, 0);

    // Randomized frames with gaps and occasional clears; long enough to wrap frame_cnt
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NC; i++) begin
        int v;
        v = int'($urandom_range(0, 4095)) - 2048;
        if ($urandom_range(0, 3) == 0) v = 17; // encourage ties
        step(1'b1, v, ($urandom_range(0, 199) == 0));
        if ($urandom_range(0, 4) == 0) step(1'b0, 0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fc_argmax_decider.md
Name: fc_argmax_decider

Overview:
Terminal classification stage. Consumes the serial stream of 10 signed 12-bit class scores produced by the fully connected layer, one score per valid cycle. It tracks the running maximum and its index. Once per 10-score frame it emits the winning class index and score with a one-cycle valid pulse. It also keeps the last frame's scores for readback and counts completed frames.

Parameters:
NUM_CLASSES, 10, scores per frame (class indices 0..NUM_CLASSES-1)
DATA_BITS, 12, score width, two's complement
IDX_BITS, 4, width of class index / counter; must satisfy 2^IDX_BITS >= NUM_CLASSES
CNT_BITS, 8, frame counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
valid_in  in  1  score strobe (driven by FC valid_out_fc); data_in is sampled when high
data_in  in  DATA_BITS  signed score of class cls_idx
clear  in  1  synchronous abort of the partial frame
decision  out  IDX_BITS  winning class index of the last completed frame
max_score  out  DATA_BITS  signed score of the winner
valid_out  out  1  one-cycle pulse: decision/max_score updated
frame_cnt  out  CNT_BITS  completed-frame count, wraps modulo 2^CNT_BITS
busy  out  1  high while a frame is partially received (cls_idx != 0)
rd_addr  in  IDX_BITS  score readback address
rd_data  out  DATA_BITS  combinational read of score buffer[rd_addr]; 0 if rd_addr >= NUM_CLASSES

Behaviour:
- Reset (rst_n low, asynchronous): cls_idx=0, run_max=0, run_idx=0, decision=0, max_score=0, valid_out=0, frame_cnt=0, busy=0, all score buffer entries=0. Takes effect immediately, including mid-frame. The partial frame is discarded with no valid_out.
- Internal state: cls_idx counter 0..NUM_CLASSES-1, run_max (signed DATA_BITS), run_idx.
- Per accepted sample (valid_in=1, clear=0):
  - buffer[cls_idx] <= data_in.
  - If cls_idx==0: run_max<=data_in, run_idx<=0.
  - Else, if data_in > run_max (signed, strictly greater): run_max<=data_in, run_idx<=cls_idx. Otherwise unchanged.
  - Ties keep the lower index.
- Frame completion: when cls_idx==NUM_CLASSES-1 and a sample is accepted:
  - The final compare is folded in the same cycle. decision and max_score are loaded with the post-compare winner on that edge.
  - valid_out=1 for exactly the following cycle.
  - frame_cnt increments; cls_idx wraps to 0.
- Latency: valid_out is high in the cycle after the edge that samples the 10th score.
- Gaps: valid_in may drop for any number of cycles mid-frame. State holds and no timeout applies.
- Back-to-back frames: the first sample of the next frame may arrive in the cycle valid_out is high. It is accepted normally.
- decision/max_score hold their value until the next frame completes.
- clear=1: cls_idx<=0; run state is discarded; no valid_out. decision, max_score, frame_cnt and the buffer are untouched.
- clear and valid_in high together: clear wins and the sample is dropped.
- If clear lands on the 10th sample, the frame does not complete.
- busy = (cls_idx != 0), registered-state derived.
- Buffer entries for indices not yet rewritten in the current frame retain the previous frame's values.
- frame_cnt wraps from 2^CNT_BITS-1 to 0 without a flag.
- Arithmetic: comparison only, no width growth; signed compare over the full DATA_BITS.

Test Plan:
- Scores 0,10,20,...,90 contiguous -> valid_out one cycle after the 10th, decision=9, max_score=90, frame_cnt=1, rd_addr=4 gives rd_data=40.
- Scores all -5 except class 3 = -2 and class 7 = -2 -> decision=3 (tie keeps lower index), max_score=-2 (0xFFE).
- All scores -100, -200, ..., -1000 -> decision=0, max_score=-100; confirms the signed compare and first-sample initialisation.
- Same frame as the first test, with 3 idle cycles between every score -> identical result; busy=1 throughout; valid_out pulses exactly once.
- 5 scores, then clear, then full frame with class 6 = 500 as max -> one valid_out only, decision=6, max_score=500. Repeat with clear on the 10th sample -> no valid_out and frame_cnt unchanged.
- Two frames back-to-back (20 contiguous valid cycles, maxima at classes 2 and 8) -> valid_out pulses one cycle after the 10th and after the 20th score, giving decision=2 then 8 and frame_cnt=2. Then assert rst_n low mid-third-frame -> all outputs 0 immediately; the next full frame yields a correct result.
